dct_row_loader: RTL and testbench

- Upstream feeder for the 8-point DCT controller.
- Accepts a serial stream of unsigned pixels over a valid/ready handshake and level-shifts each pixel to signed.
- Packs 8 consecutive pixels into one row and presents it as the parallel x0..x7 bus with the DCT's data_in_valid/data_in_ready handshake.
- Ping-pong double buffer: one row fills while the previous row waits for the DCT.

---
 rtl/dct_row_loader.sv | 136 +++++++++++++
 tb/tb_dct_row_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_row_loader.sv
// Serial pixel to parallel row feeder for the 8-point DCT: level-shift, pack 8 pixels, ping-pong buffer.
// Optional row-sync checking (pix_last / sync_err) is enabled by defining DCT_ROW_LOADER_ROW_SYNC_EN.
module dct_row_loader #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned OFFSET = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [PIX_W-1:0]        pix_data,
`ifdef DCT_ROW_LOADER_ROW_SYNC_EN
    input  logic                    pix_last,
    output logic                    sync_err,
`endif
    output logic                    data_in_valid,
    input  logic                    data_in_ready,
    output logic signed [PIX_W:0]   x0,
    output logic signed [PIX_W:0]   x1,
    output logic signed [PIX_W:0]   x2,
    output logic signed [PIX_W:0]   x3,
    output logic signed [PIX_W:0]   x4,
    output logic signed [PIX_W:0]   x5,
    output logic signed [PIX_W:0]   x6,
    output logic signed [PIX_W:0]   x7
);
    localparam int unsigned XW      = PIX_W + 1;
    localparam int unsigned ROW_LEN = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned N_BANKS = 2;

    logic signed [XW-1:0] bank_q [N_BANKS][ROW_LEN];
    logic [N_BANKS-1:0]   full_q, full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 pix_acc;
    logic                 row_acc;
    logic                 row_done;
    logic                 row_drop;
    logic signed [XW-1:0] pix_shift;

    // Handshakes depend only on registered state (and rst), never on pix_valid.
    assign pix_ready     = !rst && !full_q[wr_bank_q];
    assign pix_acc       = pix_valid && pix_ready;
    assign data_in_valid = full_q[rd_bank_q];
    assign row_acc       = data_in_valid && data_in_ready;

    // Zero-extended pixel minus offset is exact in XW bits since OFFSET < 2**PIX_W.
    assign pix_shift = $signed({1'b0, pix_data}) - $signed(XW'(OFFSET));

`ifdef DCT_ROW_LOADER_ROW_SYNC_EN
    logic sync_err_q, sync_err_d;

    assign row_drop = pix_acc && pix_last && (count_q != CNT_W'(ROW_LEN - 1));
    assign row_done = pix_acc && (count_q == CNT_W'(ROW_LEN - 1));
    assign sync_err = sync_err_q;

    always_comb begin
        sync_err_d = sync_err_q;
        if (row_drop || (row_done && !pix_last)) begin
            sync_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= sync_err_d;
        end
    end
`else
    assign row_drop = 1'b0;
    assign row_done = pix_acc && (count_q == CNT_W'(ROW_LEN - 1));
`endif

    // Fill and drain are independent; they never target the same bank in one cycle.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        count_d   = count_q;
        if (pix_acc) begin
            count_d = count_q + CNT_W'(1);
        end
        if (row_drop) begin
            count_d = '0;
        end
        if (row_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
        end
        if (row_acc) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            count_q   <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < int'(N_BANKS); b++) begin
                for (int i = 0; i < int'(ROW_LEN); i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else if (pix_acc) begin
            bank_q[wr_bank_q][count_q] <= pix_shift;
        end
    end

    assign x0 = bank_q[rd_bank_q][0];
    assign x1 = bank_q[rd_bank_q][1];
    assign x2 = bank_q[rd_bank_q][2];
    assign x3 = bank_q[rd_bank_q][3];
    assign x4 = bank_q[rd_bank_q][4];
    assign x5 = bank_q[rd_bank_q][5];
    assign x6 = bank_q[rd_bank_q][6];
    assign x7 = bank_q[rd_bank_q][7];

endmodule

// File: tb/tb_dct_row_loader.sv
// Self-checking bench for dct_row_loader: directed scenarios plus randomized traffic against a queue model.
// Row-sync scenario is compiled in when DCT_ROW_LOADER_ROW_SYNC_EN is defined.
`timescale 1ns/1ps
module tb_dct_row_loader;
    localparam int OFFSET = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_data;
    logic              data_in_valid;
    logic              data_in_ready;
    logic signed [8:0] x0, x1, x2, x3, x4, x5, x6, x7;
`ifdef DCT_ROW_LOADER_ROW_SYNC_EN
    logic              pix_last;
    logic              sync_err;
`endif
    logic [71:0]       x_bus;

    int n_checks = 0;
    int n_errors = 0;

    // Model: complete rows waiting for the DCT, and pixels of the row being gathered.
    logic [71:0] pend_q[$];
    int          cur_q[$];
    bit          m_sync_err;

    dct_row_loader dut (
        .clk           (clk),
        .rst           (rst),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
`ifdef DCT_ROW_LOADER_ROW_SYNC_EN
        .pix_last      (pix_last),
        .sync_err      (sync_err),
`endif
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .x0            (x0),
        .x1            (x1),
        .x2            (x2),
        .x3            (x3),
        .x4            (x4),
        .x5            (x5),
        .x6            (x6),
        .x7            (x7)
    );

    assign x_bus = {x7, x6, x5, x4, x3, x2, x1, x0};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] pack_cur();
        logic [71:0] r = '0;
        for (int i = 0; i < 8; i++) r[9*i +: 9] = 9'(cur_q[i]);
        return r;
    endfunction

    function automatic logic [71:0] exp_row(input int p[64], input int k);
        logic [71:0] r = '0;
        for (int i = 0; i < 8; i++) r[9*i +: 9] = 9'(p[8*k + i] - OFFSET);
        return r;
    endfunction

    // One clock: drive inputs at negedge, advance the model at posedge, return #1 later.
    task automatic tick(input bit r, input bit v, input logic [7:0] d, input bit rdy, output bit acc);
        bit pa, ra;
        @(negedge clk);
        rst = r; pix_valid = v; pix_data = d; data_in_ready = rdy;
        pa = !r && v && (pend_q.size() < 2);
        ra = !r && rdy && (pend_q.size() > 0);
        @(posedge clk);
        if (r) begin
            pend_q.delete(); cur_q.delete(); m_sync_err = 1'b0;
        end else begin
            if (ra) void'(pend_q.pop_front());
            if (pa) begin
                cur_q.push_back(int'(d) - OFFSET);
`ifdef DCT_ROW_LOADER_ROW_SYNC_EN
                if (pix_last && cur_q.size() < 8) begin
                    cur_q.delete(); m_sync_err = 1'b1;
                end else if (!pix_last && cur_q.size() == 8) begin
                    m_sync_err = 1'b1;
                end
`endif
                if (cur_q.size() == 8) begin
                    pend_q.push_back(pack_cur()); cur_q.delete();
                end
            end
        end
        acc = pa;
        #1;
    endtask

    task automatic do_reset();
        bit a;
        tick(1, 0, 8'd0, 0, a);
        tick(1, 0, 8'd0, 0, a);
    endtask

    task automatic test_reset();
        bit a;
        tick(1, 1, 8'hAA, 1, a);
        tick(1, 1, 8'hAA, 1, a);
        n_checks++; if (pix_ready !== 1'b0) begin n_errors++; $display("FAIL reset_pix_ready got %b exp 0", pix_ready); end
        n_checks++; if (data_in_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", data_in_valid); end
        n_checks++; if (x_bus !== 72'd0) begin n_errors++; $display("FAIL reset_x got %h exp 0", x_bus); end
        tick(0, 0, 8'd0, 0, a);
        n_checks++; if (pix_ready !== 1'b1) begin n_errors++; $display("FAIL release_pix_ready got %b exp 1", pix_ready); end
        n_checks++; if (data_in_valid !== 1'b0) begin n_errors++; $display("FAIL release_valid got %b exp 0", data_in_valid); end
    endtask

    task automatic test_basic();
        bit a;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 8'(138 + 10*i), 1, a);
            if (i < 7) begin
                n_checks++; if (data_in_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early_valid px%0d got %b exp 0", i, data_in_valid); end
            end
        end
        n_checks++; if (data_in_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid got %b exp 1", data_in_valid); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (x_bus[9*i +: 9] !== 9'(10*(i+1))) begin
                n_errors++; $display("FAIL basic_x%0d got %0d exp %0d", i, $signed(x_bus[9*i +: 9]), 10*(i+1));
            end
        end
        tick(0, 0, 8'd0, 1, a);
        n_checks++; if (data_in_valid !== 1'b0) begin n_errors++; $display("FAIL basic_valid_drop got %b exp 0", data_in_valid); end
    endtask

    task automatic test_sign();
        bit a;
        int px[8] = '{0, 255, 128, 127, 1, 2, 3, 4};
        do_reset();
        for (int i = 0; i < 8; i++) tick(0, 1, 8'(px[i]), 0, a);
        n_checks++; if (data_in_valid !== 1'b1) begin n_errors++; $display("FAIL sign_valid got %b exp 1", data_in_valid); end
        n_checks++; if (x0 !== 9'h180) begin n_errors++; $display("FAIL sign_x0 got %0d exp -128", x0); end
        n_checks++; if (x1 !== 9'h07F) begin n_errors++; $display("FAIL sign_x1 got %0d exp 127", x1); end
        n_checks++; if (x2 !== 9'h000) begin n_errors++; $display("FAIL sign_x2 got %0d exp 0", x2); end
        n_checks++; if (x3 !== 9'h1FF) begin n_errors++; $display("FAIL sign_x3 got %0d exp -1", x3); end
        n_checks++; if (x7 !== 9'h184) begin n_errors++; $display("FAIL sign_x7 got %0d exp -124", x7); end
    endtask

    task automatic test_stall();
        bit a;
        int p[64];
        int idx = 0;
        for (int i = 0; i < 64; i++) p[i] = int'($urandom_range(0, 255));
        do_reset();
        for (int c = 0; c < 24; c++) begin
            tick(0, idx < 17, 8'(p[idx < 17 ? idx : 0]), 0, a);
            if (a) idx++;
            if (idx >= 8) begin
                n_checks++; if (x_bus !== exp_row(p, 0)) begin n_errors++; $display("FAIL stall_row1_hold c%0d got %h exp %h", c, x_bus, exp_row(p, 0)); end
            end
        end
        n_checks++; if (idx != 16) begin n_errors++; $display("FAIL stall_accepts got %0d exp 16", idx); end
        n_checks++; if (pix_ready !== 1'b0) begin n_errors++; $display("FAIL stall_pix_ready got %b exp 0", pix_ready); end
        n_checks++; if (data_in_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid got %b exp 1", data_in_valid); end
        tick(0, 1, 8'(p[16]), 1, a);
        n_checks++; if (a) begin n_errors++; $display("FAIL stall_17th_early got accepted exp held"); end
        n_checks++; if (data_in_valid !== 1'b1) begin n_errors++; $display("FAIL stall_row2_valid got %b exp 1", data_in_valid); end
        n_checks++; if (x_bus !== exp_row(p, 1)) begin n_errors++; $display("FAIL stall_row2 got %h exp %h", x_bus, exp_row(p, 1)); end
        n_checks++; if (pix_ready !== 1'b1) begin n_errors++; $display("FAIL stall_ready_back got %b exp 1", pix_ready); end
        tick(0, 1, 8'(p[16]), 1, a);
        n_checks++; if (data_in_valid !== 1'b0) begin n_errors++; $display("FAIL stall_drained got %b exp 0", data_in_valid); end
        n_checks++; if (!a) begin n_errors++; $display("FAIL stall_17th got held exp accepted"); end
    endtask

    task automatic test_back_to_back();
        bit a;
        int p[64];
        int idx = 0, rows = 0, last_c = -1;
        for (int i = 0; i < 64; i++) p[i] = int'($urandom_range(0, 255));
        do_reset();
        for (int c = 0; c < 72; c++) begin
            tick(0, idx < 64, 8'(p[idx < 64 ? idx : 0]), 1, a);
            if (a) idx++;
            if (idx < 64) begin
                n_checks++; if (pix_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready c%0d got %b exp 1", c, pix_ready); end
            end
            if (data_in_valid === 1'b1 && rows < 8) begin
                n_checks++; if (x_bus !== exp_row(p, rows)) begin n_errors++; $display("FAIL b2b_row%0d got %h exp %h", rows, x_bus, exp_row(p, rows)); end
                if (last_c >= 0) begin
                    n_checks++; if (c - last_c != 8) begin n_errors++; $display("FAIL b2b_spacing row%0d got %0d exp 8", rows, c - last_c); end
                end
                last_c = c;
                rows++;
            end
        end
        n_checks++; if (rows != 8) begin n_errors++; $display("FAIL b2b_rows got %0d exp 8", rows); end
    endtask

    task automatic test_reset_mid();
        bit a;
        int p[64];
        for (int i = 0; i < 64; i++) p[i] = int'($urandom_range(0, 255));
        do_reset();
        for (int i = 0; i < 5; i++) tick(0, 1, 8'($urandom_range(0, 255)), 1, a);
        for (int i = 0; i < 2; i++) begin
            tick(1, 1, 8'hFF, 1, a);
            n_checks++; if (data_in_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid_in_rst got %b exp 0", data_in_valid); end
            n_checks++; if (pix_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_ready_in_rst got %b exp 0", pix_ready); end
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 8'(p[i]), 0, a);
            if (i < 7) begin
                n_checks++; if (data_in_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_early_valid px%0d got %b exp 0", i, data_in_valid); end
            end
        end
        n_checks++; if (data_in_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_valid got %b exp 1", data_in_valid); end
        n_checks++; if (x_bus !== exp_row(p, 0)) begin n_errors++; $display("FAIL rstmid_row got %h exp %h", x_bus, exp_row(p, 0)); end
    endtask

    task automatic test_random();
        bit a;
        int errs_before = n_errors;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            tick(0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0, a);
            n_checks++; if (pix_ready !== (pend_q.size() < 2)) begin n_errors++; $display("FAIL rand_ready c%0d got %b exp %b", c, pix_ready, pend_q.size() < 2); end
            n_checks++; if (data_in_valid !== (pend_q.size() > 0)) begin n_errors++; $display("FAIL rand_valid c%0d got %b exp %b", c, data_in_valid, pend_q.size() > 0); end
            if (pend_q.size() > 0) begin
                n_checks++; if (x_bus !== pend_q[0]) begin n_errors++; $display("FAIL rand_row c%0d got %h exp %h", c, x_bus, pend_q[0]); end
            end
            if (n_errors - errs_before > 10) break;
        end
    endtask

`ifdef DCT_ROW_LOADER_ROW_SYNC_EN
    task automatic test_row_sync();
        bit a;
        int p[64];
        for (int i = 0; i < 64; i++) p[i] = int'($urandom_range(0, 255));
        pix_last = 1'b0;
        do_reset();
        n_checks++; if (sync_err !== 1'b0) begin n_errors++; $display("FAIL sync_reset got %b exp 0", sync_err); end
        for (int i = 0; i < 5; i++) begin
            pix_last = (i == 4);
            tick(0, 1, 8'($urandom_range(0, 255)), 1, a);
        end
        pix_last = 1'b0;
        tick(0, 0, 8'd0, 1, a);
        n_checks++; if (data_in_valid !== 1'b0) begin n_errors++; $display("FAIL sync_short_valid got %b exp 0", data_in_valid); end
        n_checks++; if (sync_err !== 1'b1) begin n_errors++; $display("FAIL sync_short_err got %b exp 1", sync_err); end
        for (int i = 0; i < 8; i++) begin
            pix_last = (i == 7);
            tick(0, 1, 8'(p[i]), 0, a);
        end
        pix_last = 1'b0;
        n_checks++; if (data_in_valid !== 1'b1) begin n_errors++; $display("FAIL sync_row_valid got %b exp 1", data_in_valid); end
        n_checks++; if (x_bus !== exp_row(p, 0)) begin n_errors++; $display("FAIL sync_row got %h exp %h", x_bus, exp_row(p, 0)); end
        n_checks++; if (sync_err !== 1'b1) begin n_errors++; $display("FAIL sync_sticky got %b exp 1", sync_err); end
        do_reset();
        for (int i = 8; i < 16; i++) tick(0, 1, 8'(p[i]), 0, a);
        n_checks++; if (x_bus !== exp_row(p, 1) || data_in_valid !== 1'b1) begin n_errors++; $display("FAIL sync_long_row got %h/%b exp %h/1", x_bus, data_in_valid, exp_row(p, 1)); end
        n_checks++; if (sync_err !== m_sync_err || sync_err !== 1'b1) begin n_errors++; $display("FAIL sync_long_err got %b exp 1", sync_err); end
    endtask
`endif

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_data = 8'd0; data_in_ready = 1'b0;
`ifdef DCT_ROW_LOADER_ROW_SYNC_EN
        pix_last = 1'b0;
`endif
        test_reset();
        test_basic();
        test_sign();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef DCT_ROW_LOADER_ROW_SYNC_EN
        test_row_sync();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
